seg_display_scheduler: RTL

Time-shares the single 8-digit seven-segment display between N_SRC debug value sources. It rotates round-robin through the sources that are currently valid, dwelling DWELL_CYCLES on each, and supports a pinned mode, a rotation freeze, and per-slot value snapshotting. val_out drives the val_in input of the seven-segment controller directly.

---
 rtl/seg_sched_pkg.sv | 16 +
 rtl/seg_rr_next.sv | 26 ++
 rtl/seg_display_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    PINNED
  } state_e;

  localparam int unsigned TAG_NIBBLE_LSB = 28;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_rr_next.sv
// Combinational round-robin finder: first valid index strictly after start_in,
// wrapping, with start_in itself checked last.
module seg_rr_next #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_SRC-1:0] valid_in,
  input  logic [SEL_W-1:0] start_in,
  output logic [SEL_W-1:0] next_out,
  output logic             found_out
);

  always_comb begin
    next_out  = '0;
    found_out = 1'b0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (!found_out && valid_in[i] && (i == (32'(start_in) + k) % N_SRC)) begin
          next_out  = SEL_W'(i);
          found_out = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 8-digit seven-segment display between
// N_SRC debug sources, with pinning, dwell freeze and per-slot snapshotting.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned SHOW_TAG     = 1,
  parameter int unsigned SEL_W        = sel_width(N_SRC)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [32*N_SRC-1:0]  src_val_in,
  input  logic [N_SRC-1:0]     src_valid_in,
  input  logic                 pin_en_in,
  input  logic [SEL_W-1:0]     pin_sel_in,
  input  logic                 hold_in,
  input  logic                 snapshot_en_in,
  output logic [31:0]          val_out,
  output logic [SEL_W-1:0]     src_idx_out,
  output logic                 active_out,
  output logic                 slot_start_out
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [31:0]       dwell_q, dwell_d;
  logic [31:0]       val_q, val_d;
  logic              active_q, active_d;
  logic              ss_q, ss_d;

  logic [SEL_W-1:0]  rr_start, rr_next;
  logic              rr_found;
  logic              cur_valid;
  logic [31:0]       sel_val;

  // IDLE resumes the rotation after the last source shown; otherwise search after idx.
  assign rr_start = (state_q == IDLE) ? last_q : idx_q;

  seg_rr_next #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_rr_next (
    .valid_in  (src_valid_in),
    .start_in  (rr_start),
    .next_out  (rr_next),
    .found_out (rr_found)
  );

  always_comb begin
    cur_valid = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (32'(idx_q) == i) cur_valid = src_valid_in[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    ss_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pin_en_in) begin
          state_d = PINNED;
          idx_d   = pin_sel_in;
          dwell_d = '0;
          ss_d    = 1'b1;
        end else if (rr_found) begin
          state_d = SHOW;
          idx_d   = rr_next;
          dwell_d = '0;
          ss_d    = 1'b1;
        end
      end
      SHOW: begin
        if (pin_en_in) begin
          state_d = PINNED;
          idx_d   = pin_sel_in;
          dwell_d = '0;
          ss_d    = 1'b1;
        end else if (!cur_valid) begin
          dwell_d = '0;
          if (rr_found) begin
            idx_d = rr_next;
            ss_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!hold_in && dwell_q == DWELL_LAST) begin
          // idx is valid, so the search always succeeds (possibly reselecting idx).
          idx_d   = rr_next;
          dwell_d = '0;
          ss_d    = 1'b1;
        end else if (!hold_in) begin
          dwell_d = dwell_q + 32'd1;
        end
      end
      PINNED: begin
        dwell_d = '0;
        if (pin_en_in) begin
          idx_d = pin_sel_in;
          ss_d  = (pin_sel_in != idx_q);
        end else if (cur_valid) begin
          state_d = SHOW;
          ss_d    = 1'b1;
        end else if (rr_found) begin
          state_d = SHOW;
          idx_d   = rr_next;
          ss_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_d = ss_d ? idx_d : last_q;

  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (32'(idx_d) == i) sel_val = src_val_in[32*i +: 32];
    end
  end

  always_comb begin
    active_d = (state_d == SHOW) || (state_d == PINNED && 32'(idx_d) < N_SRC);
    val_d    = '0;
    if (active_d) begin
      if (snapshot_en_in && !ss_d) begin
        val_d = val_q;
      end else begin
        val_d = sel_val;
        if (SHOW_TAG != 0) val_d[TAG_NIBBLE_LSB +: 4] = 4'(idx_d);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= SEL_W'(N_SRC - 1);
      dwell_q  <= '0;
      val_q    <= '0;
      active_q <= 1'b0;
      ss_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      dwell_q  <= dwell_d;
      val_q    <= val_d;
      active_q <= active_d;
      ss_q     <= ss_d;
    end
  end

  assign val_out        = val_q;
  assign src_idx_out    = idx_q;
  assign active_out     = active_q;
  assign slot_start_out = ss_q;

endmodule
